// File: rtl/crp16_alu_wb_if.sv
// Handshake bundle between the CRP16 ALU, the writeback stage and the register-file write port.
// The slave modport is the writeback stage; the master modport is whoever drives and drains it.
interface crp16_alu_wb_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic        in_n;
  logic        in_z;
  logic        in_c;
  logic        in_v;
  logic [2:0]  in_rd;
  logic        in_wr_en;
  logic        in_set_flags;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_rd;
  logic        out_wr_en;

  modport slave (
    input  in_valid, in_result, in_n, in_z, in_c, in_v, in_rd, in_wr_en, in_set_flags,
    output in_ready,
    output out_valid, out_result, out_rd, out_wr_en,
    input  out_ready
  );

  modport master (
    output in_valid, in_result, in_n, in_z, in_c, in_v, in_rd, in_wr_en, in_set_flags,
    input  in_ready,
    input  out_valid, out_result, out_rd, out_wr_en,
    output out_ready
  );
endinterface

// File: rtl/crp16_alu_wb.sv
// CRP16 writeback stage: 2-entry skid FIFO for the register-file port, flag register and branch condition evaluation.
// Define CRP16_FLAG_BYPASS_EN to evaluate cond_true against the flags being written this cycle.
module crp16_alu_wb (
  input  logic                  clock,
  input  logic                  reset,
  crp16_alu_wb_if.slave         bus,
  output logic [3:0]            flags,
  input  logic [2:0]            cond_sel,
  output logic                  cond_true
);

  logic [15:0] r_result [2];
  logic [2:0]  r_rd     [2];
  logic        r_wrEn   [2];
  logic        r_rdPtr;
  logic        r_wrPtr;
  logic [1:0]  r_count;
  logic [3:0]  r_flags;

  logic        w_push;
  logic        w_pop;
  logic [3:0]  w_inFlags;
  logic [3:0]  w_condFlags;

  // Handshake status depends only on the registered count, so no ready/valid combinational loops.
  assign bus.in_ready  = (r_count != 2'd2);
  assign bus.out_valid = (r_count != 2'd0);

  assign w_push    = bus.in_valid  & bus.in_ready;
  assign w_pop     = bus.out_valid & bus.out_ready;
  assign w_inFlags = {bus.in_n, bus.in_z, bus.in_c, bus.in_v};

  assign bus.out_result = r_result[r_rdPtr];
  assign bus.out_rd     = r_rd[r_rdPtr];
  assign bus.out_wr_en  = bus.out_valid & r_wrEn[r_rdPtr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        r_result[i] <= 16'h0000;
        r_rd[i]     <= 3'd0;
        r_wrEn[i]   <= 1'b0;
      end
    end else if (w_push) begin
      r_result[r_wrPtr] <= bus.in_result;
      r_rd[r_wrPtr]     <= bus.in_rd;
      r_wrEn[r_wrPtr]   <= bus.in_wr_en;
    end
  end

  // Simultaneous push and pop advances both pointers and leaves the count alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rdPtr <= 1'b0;
      r_wrPtr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wrPtr <= ~r_wrPtr;
      if (w_pop)  r_rdPtr <= ~r_rdPtr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Flags commit when the operation is accepted, not when its entry drains.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else if (w_push && bus.in_set_flags) begin
      r_flags <= w_inFlags;
    end
  end

  assign flags = r_flags;

`ifdef CRP16_FLAG_BYPASS_EN
  assign w_condFlags = (w_push && bus.in_set_flags) ? w_inFlags : r_flags;
`else
  assign w_condFlags = r_flags;
`endif

  // Flag order is {N,Z,C,V}; C=1 means no borrow, so LTU is ~C.
  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = w_condFlags[2];
      3'b010:  cond_true = ~w_condFlags[2];
      3'b011:  cond_true = w_condFlags[3] ^ w_condFlags[0];
      3'b100:  cond_true = ~(w_condFlags[3] ^ w_condFlags[0]);
      3'b101:  cond_true = ~w_condFlags[1];
      3'b110:  cond_true = w_condFlags[1];
      default: cond_true = 1'b0;
    endcase
  end

endmodule
